lc3b_instr_writer: RTL and testbench

//  Inverse of the IR field decode: takes LC-3b instruction fields (opcode, regs, imm/offsets,

---
 rtl/lc3b_instr_writer_pkg.sv | 43 ++++
 rtl/lc3b_instr_encode.sv | 42 ++++
 rtl/lc3b_instr_writer.sv | 134 +++++++++++++
 tb/tb_lc3b_instr_writer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_instr_writer_pkg.sv
// rtl/lc3b_instr_writer_pkg.sv - LC-3b field types, encoding formats and writer FSM states
//
// Shared types for the instruction writer and its encoder:
//   lc3b_word / lc3b_opcode / lc3b_reg / lc3b_imm5 / lc3b_offset6/9/11 /
//   lc3b_trapvect8 / lc3b_imm_bit  - raw instruction field widths
//   lc3b_fmt                       - encoding format select (codes 6,7 = opcode only)
//   writer_state_t                 - IDLE -> WRITE -> DONE -> IDLE
package lc3b_instr_writer_pkg;

    typedef logic [15:0] lc3b_word;
    typedef logic [3:0]  lc3b_opcode;
    typedef logic [2:0]  lc3b_reg;
    typedef logic [4:0]  lc3b_imm5;
    typedef logic [5:0]  lc3b_offset6;
    typedef logic [8:0]  lc3b_offset9;
    typedef logic [10:0] lc3b_offset11;
    typedef logic [7:0]  lc3b_trapvect8;
    typedef logic        lc3b_imm_bit;

    typedef enum logic [2:0] {
        FMT_ARITH = 3'd0,
        FMT_OFF6  = 3'd1,
        FMT_OFF9  = 3'd2,
        FMT_OFF11 = 3'd3,
        FMT_TRAP  = 3'd4,
        FMT_JMP   = 3'd5
    } lc3b_fmt;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } writer_state_t;

    // Word pointers and write addresses are always halfword aligned.
    localparam lc3b_word WORD_ALIGN_MASK = 16'hFFFE;
    localparam lc3b_word WORD_STRIDE     = 16'd2;

    function automatic lc3b_word align_word(input lc3b_word addr);
        return addr & WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/lc3b_instr_encode.sv
// rtl/lc3b_instr_encode.sv - combinational LC-3b field bundle to instruction word packer
//
// Ports:
//   fmt                    in  encoding format (lc3b_fmt code, 6/7 = opcode only)
//   opcode                 in  bits [15:12]
//   dest, src1, src2       in  register fields
//   imm_bit                in  bit 5 for ARITH, bit 11 for OFF11
//   imm5, offset6, offset9, offset11, trapvect8  in  immediate / offset fields
//   word                   out packed 16-bit instruction
import lc3b_instr_writer_pkg::*;

module lc3b_instr_encode (
    input  logic [2:0]  fmt,
    input  logic [3:0]  opcode,
    input  logic [2:0]  dest,
    input  logic [2:0]  src1,
    input  logic [2:0]  src2,
    input  logic        imm_bit,
    input  logic [4:0]  imm5,
    input  logic [5:0]  offset6,
    input  logic [8:0]  offset9,
    input  logic [10:0] offset11,
    input  logic [7:0]  trapvect8,
    output logic [15:0] word
);

    always_comb begin
        word = {opcode, 12'h000};
        case (lc3b_fmt'(fmt))
            // Register form keeps bits [4:3] zero; immediate form replaces them with imm5.
            FMT_ARITH: word = {opcode, dest, src1, imm_bit,
                               (imm_bit ? imm5 : {2'b00, src2})};
            FMT_OFF6:  word = {opcode, dest, src1, offset6};
            FMT_OFF9:  word = {opcode, dest, offset9};
            FMT_OFF11: word = {opcode, imm_bit, offset11};
            FMT_TRAP:  word = {opcode, 4'h0, trapvect8};
            FMT_JMP:   word = {opcode, 3'b000, src1, 6'h00};
            default:   word = {opcode, 12'h000};
        endcase
    end

endmodule

// File: rtl/lc3b_instr_writer.sv
// rtl/lc3b_instr_writer.sv - packs LC-3b fields and writes them to memory at an auto-incrementing pointer
//
// Ports:
//   clk, reset           clock; asynchronous active-high reset
//   base_load, base_addr reload write pointer (IDLE only, bit 0 dropped)
//   req                  field bundle valid (level); fields sampled on acceptance
//   fmt .. trapvect8     instruction fields, see lc3b_instr_encode
//   ack                  one-cycle pulse when a word has been committed
//   busy                 high outside IDLE
//   words_written        committed word count, wraps
//   mem_address, mem_wdata, mem_write, mem_byte_enable, mem_resp  memory write port
import lc3b_instr_writer_pkg::*;

module lc3b_instr_writer #(
    parameter logic [15:0] RESET_BASE  = 16'h0000,
    parameter int          COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   base_load,
    input  logic [15:0]            base_addr,
    input  logic                   req,
    input  logic [2:0]             fmt,
    input  logic [3:0]             opcode,
    input  logic [2:0]             dest,
    input  logic [2:0]             src1,
    input  logic [2:0]             src2,
    input  logic                   imm_bit,
    input  logic [4:0]             imm5,
    input  logic [5:0]             offset6,
    input  logic [8:0]             offset9,
    input  logic [10:0]            offset11,
    input  logic [7:0]             trapvect8,
    output logic                   ack,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] words_written,
    output logic [15:0]            mem_address,
    output logic [15:0]            mem_wdata,
    output logic                   mem_write,
    output logic [1:0]             mem_byte_enable,
    input  logic                   mem_resp
);

    writer_state_t state, state_next;
    lc3b_word      ptr;
    lc3b_word      enc_word;
    logic          accept;

    lc3b_instr_encode u_encode (
        .fmt       (fmt),
        .opcode    (opcode),
        .dest      (dest),
        .src1      (src1),
        .src2      (src2),
        .imm_bit   (imm_bit),
        .imm5      (imm5),
        .offset6   (offset6),
        .offset9   (offset9),
        .offset11  (offset11),
        .trapvect8 (trapvect8),
        .word      (enc_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // base_load takes priority over req so a pointer reload never races a write.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!base_load && req) begin
                    accept     = 1'b1;
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (mem_resp) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Memory-side outputs are registered so address/data stay frozen for the
    // whole WRITE phase regardless of what the field inputs do.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr             <= align_word(RESET_BASE);
            words_written   <= '0;
            mem_address     <= '0;
            mem_wdata       <= '0;
            mem_write       <= 1'b0;
            mem_byte_enable <= 2'b00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (base_load) begin
                        ptr <= align_word(base_addr);
                    end else if (accept) begin
                        mem_wdata       <= enc_word;
                        mem_address     <= ptr;
                        mem_write       <= 1'b1;
                        mem_byte_enable <= 2'b11;
                    end
                end
                ST_WRITE: begin
                    if (mem_resp) begin
                        mem_write       <= 1'b0;
                        mem_byte_enable <= 2'b00;
                    end
                end
                ST_DONE: begin
                    // 16-bit add wraps 0xFFFE to 0x0000 naturally.
                    ptr           <= ptr + WORD_STRIDE;
                    words_written <= words_written + COUNT_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    assign ack  = (state == ST_DONE);
    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_lc3b_instr_writer.sv
// tb/tb_lc3b_instr_writer.sv - directed self-checking bench for lc3b_instr_writer
module tb_lc3b_instr_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        base_load;
    logic [15:0] base_addr;
    logic        req;
    logic [2:0]  fmt;
    logic [3:0]  opcode;
    logic [2:0]  dest, src1, src2;
    logic        imm_bit;
    logic [4:0]  imm5;
    logic [5:0]  offset6;
    logic [8:0]  offset9;
    logic [10:0] offset11;
    logic [7:0]  trapvect8;
    logic        ack, busy;
    logic [15:0] words_written;
    logic [15:0] mem_address, mem_wdata;
    logic        mem_write;
    logic [1:0]  mem_byte_enable;
    logic        mem_resp;

    int checks = 0;
    int errors = 0;

    lc3b_instr_writer #(.RESET_BASE(16'h0000), .COUNT_WIDTH(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .base_load       (base_load),
        .base_addr       (base_addr),
        .req             (req),
        .fmt             (fmt),
        .opcode          (opcode),
        .dest            (dest),
        .src1            (src1),
        .src2            (src2),
        .imm_bit         (imm_bit),
        .imm5            (imm5),
        .offset6         (offset6),
        .offset9         (offset9),
        .offset11        (offset11),
        .trapvect8       (trapvect8),
        .ack             (ack),
        .busy            (busy),
        .words_written   (words_written),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_resp        (mem_resp)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fields();
        fmt = 3'd0; opcode = 4'h0; dest = 3'd0; src1 = 3'd0; src2 = 3'd0;
        imm_bit = 1'b0; imm5 = 5'h0; offset6 = 6'h0; offset9 = 9'h0;
        offset11 = 11'h0; trapvect8 = 8'h0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic do_base_load(input logic [15:0] addr);
        base_load = 1'b1;
        base_addr = addr;
        tick();
        base_load = 1'b0;
        check_eq("base_load_idle", {30'd0, busy, mem_write}, 32'd0);
    endtask

    // Caller leaves the DUT in IDLE with fields set. Fields are scrambled after
    // acceptance whenever a response delay is used.
    task automatic do_write(input string tag, input logic [15:0] ea, input logic [15:0] ed,
                            input int delay);
        req = 1'b1;
        tick();
        req = 1'b0;
        check_eq({tag, "_mw"},   mem_write, 1);
        check_eq({tag, "_addr"}, mem_address, ea);
        check_eq({tag, "_data"}, mem_wdata, ed);
        check_eq({tag, "_be"},   mem_byte_enable, 2'b11);
        check_eq({tag, "_busy"}, busy, 1);
        if (delay > 0) begin
            opcode = ~opcode; fmt = fmt + 3'd1; dest = ~dest; src1 = ~src1;
            imm5 = ~imm5; imm_bit = ~imm_bit; trapvect8 = ~trapvect8;
        end
        for (int i = 0; i < delay; i++) begin
            tick();
            check_eq({tag, "_hold_mw"},   mem_write, 1);
            check_eq({tag, "_hold_addr"}, mem_address, ea);
            check_eq({tag, "_hold_data"}, mem_wdata, ed);
            check_eq({tag, "_hold_ack"},  ack, 0);
        end
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0;
        check_eq({tag, "_ack"},     ack, 1);
        check_eq({tag, "_mw_drop"}, mem_write, 0);
        tick();
        check_eq({tag, "_ack_end"}, ack, 0);
        check_eq({tag, "_idle"},    busy, 0);
    endtask

    initial begin
        reset = 1'b1; base_load = 1'b0; base_addr = 16'h0; req = 1'b0; mem_resp = 1'b0;
        clear_fields();
        tick();
        // 1: reset state and basic ARITH register form
        check_eq("rst_ack",  ack, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ww",   words_written, 0);
        check_eq("rst_mw",   mem_write, 0);
        check_eq("rst_addr", mem_address, 0);
        check_eq("rst_data", mem_wdata, 0);
        check_eq("rst_be",   mem_byte_enable, 0);
        reset = 1'b0;
        tick();
        fmt = 3'd0; opcode = 4'b0001; dest = 3'd1; src1 = 3'd2; src2 = 3'd3; imm_bit = 1'b0;
        do_write("t1", 16'h0000, 16'h1283, 0);
        check_eq("t1_ww", words_written, 1);

        // 2: ARITH immediate form, OFF6
        imm_bit = 1'b1; imm5 = 5'h1F;
        do_write("t2a", 16'h0002, 16'h12BF, 0);
        clear_fields();
        fmt = 3'd1; opcode = 4'b0110; dest = 3'd4; src1 = 3'd5; offset6 = 6'h3E;
        do_write("t2b", 16'h0004, 16'h697E, 0);

        // 3: base reload, TRAP, JMP, base_load beats req
        do_base_load(16'h3001);
        clear_fields();
        fmt = 3'd4; opcode = 4'hF; trapvect8 = 8'h25;
        do_write("t3a", 16'h3000, 16'hF025, 0);
        clear_fields();
        fmt = 3'd5; opcode = 4'b1100; src1 = 3'd3;
        do_write("t3b", 16'h3002, 16'hC0C0, 0);
        clear_fields();
        fmt = 3'd2; opcode = 4'b0010; dest = 3'd5; offset9 = 9'h1A5;
        req = 1'b1;
        do_base_load(16'h4000);
        do_write("t3c", 16'h4000, 16'h2BA5, 0);
        check_eq("t3_ww", words_written, 6);

        // 4: pointer wrap
        apply_reset();
        do_base_load(16'hFFFE);
        clear_fields();
        fmt = 3'd3; opcode = 4'b0100; imm_bit = 1'b1; offset11 = 11'h123;
        do_write("t4a", 16'hFFFE, 16'h4923, 0);
        clear_fields();
        fmt = 3'd6; opcode = 4'b1101; dest = 3'd7; offset9 = 9'h1FF;
        do_write("t4b", 16'h0000, 16'hD000, 0);
        check_eq("t4_ww", words_written, 2);

        // 5: slow memory with fields changing after accept, then back-to-back via held req
        clear_fields();
        fmt = 3'd0; opcode = 4'b0101; dest = 3'd7; src1 = 3'd6; imm_bit = 1'b1; imm5 = 5'h10;
        do_write("t5a", 16'h0002, 16'h5FB0, 5);
        clear_fields();
        fmt = 3'd4; opcode = 4'hF; trapvect8 = 8'hAA;
        req = 1'b1;
        tick();
        check_eq("t5b_addr", mem_address, 16'h0004);
        check_eq("t5b_data", mem_wdata, 16'hF0AA);
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0;
        check_eq("t5b_ack", ack, 1);
        tick();
        check_eq("t5b_gap_busy", busy, 0);
        check_eq("t5b_gap_ack", ack, 0);
        tick();
        req = 1'b0;
        check_eq("t5c_mw",   mem_write, 1);
        check_eq("t5c_addr", mem_address, 16'h0006);
        check_eq("t5c_data", mem_wdata, 16'hF0AA);
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0;
        check_eq("t5c_ack", ack, 1);
        tick();
        check_eq("t5_ww", words_written, 5);

        // 6: reset mid-WRITE
        req = 1'b1;
        tick();
        req = 1'b0;
        check_eq("t6_pre_mw", mem_write, 1);
        #2 reset = 1'b1;
        #1;
        check_eq("t6_mw",   mem_write, 0);
        check_eq("t6_busy", busy, 0);
        check_eq("t6_ww",   words_written, 0);
        check_eq("t6_addr", mem_address, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        do_write("t6_after", 16'h0000, 16'hF0AA, 0);
        check_eq("t6_ww_after", words_written, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
